// File: rtl/regfile_pkg.sv
// Shared types and default parameter values for the parametrised register file
// and its dump sequencer.
package regfile_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } dump_state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_NUM_READ   = 2;
   localparam int DEF_ZERO_REG   = 0;
   localparam int DEF_BYPASS     = 1;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: detects the rising edge of complete, walks the register
// indices over a valid/ready handshake and pulses done after the last word.
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_complete,
   input  logic                  i_dump_ready,
   output logic                  o_dump_valid,
   output logic [ADDR_WIDTH-1:0] o_dump_address,
   output logic                  o_dump_last,
   output logic                  o_dump_done,
   output logic                  o_busy
);

   dump_state_t           r_state;
   dump_state_t           w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_addr_next;
   logic                  r_complete;
   logic                  r_armed;
   logic                  w_start;
   logic                  w_last;

   // r_armed blocks a start until complete has been seen low once since reset,
   // so a level still high when reset is released does not launch a dump.
   assign w_start = i_complete && !r_complete && r_armed;
   assign w_last  = (r_addr == ADDR_WIDTH'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_complete <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_addr     <= w_addr_next;
         r_complete <= i_complete;
         if (!i_complete)
            r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_next = DUMP;
               w_addr_next  = '0;
            end
         end
         DUMP: begin
            if (i_dump_ready) begin
               if (w_last) begin
                  w_state_next = DONE;
                  w_addr_next  = '0;
               end else begin
                  w_addr_next = r_addr + 1'b1;
               end
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_dump_valid   = (r_state == DUMP);
      o_dump_last    = (r_state == DUMP) && w_last;
      o_dump_done    = (r_state == DONE);
      o_busy         = (r_state != IDLE);
      o_dump_address = r_addr;
   end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with N combinational read ports, optional zero
// register, write-to-read bypass, asynchronous clear and a handshake dump port.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int ZERO_REG   = DEF_ZERO_REG,
   parameter int BYPASS     = DEF_BYPASS
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_write,
   input  logic [ADDR_WIDTH-1:0]          i_write_address,
   input  logic [DATA_WIDTH-1:0]          i_write_data,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] i_read_address,
   output logic [NUM_READ*DATA_WIDTH-1:0] o_read_data,
   input  logic                           i_complete,
   output logic                           o_dump_valid,
   input  logic                           i_dump_ready,
   output logic [ADDR_WIDTH-1:0]          o_dump_address,
   output logic [DATA_WIDTH-1:0]          o_dump_data,
   output logic                           o_dump_last,
   output logic                           o_dump_done,
   output logic                           o_busy,
   output logic                           o_write_dropped
);

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic                  r_write_dropped;
   logic                  w_busy;
   logic                  w_write_ok;
   logic [ADDR_WIDTH-1:0] w_dump_address;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign w_write_ok = i_write && !w_busy && in_range(i_write_address)
                       && !is_zero_reg(i_write_address);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_write_ok) begin
         r_regs[i_write_address] <= i_write_data;
      end
   end

   // Sticky: a dump in progress froze the array and a write was lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_write_dropped <= 1'b0;
      else if (i_write && w_busy)
         r_write_dropped <= 1'b1;
   end

   for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0] w_data;

      assign w_addr = i_read_address[gi*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         if (!in_range(w_addr) || is_zero_reg(w_addr))
            w_data = '0;
         else if ((BYPASS != 0) && i_write && !w_busy && (w_addr == i_write_address))
            w_data = i_write_data;
         else
            w_data = r_regs[w_addr];
      end

      assign o_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_data;
   end

   regfile_dump_fsm #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dump_fsm (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_complete     (i_complete),
      .i_dump_ready   (i_dump_ready),
      .o_dump_valid   (o_dump_valid),
      .o_dump_address (w_dump_address),
      .o_dump_last    (o_dump_last),
      .o_dump_done    (o_dump_done),
      .o_busy         (w_busy)
   );

   assign o_dump_address  = w_dump_address;
   assign o_dump_data     = is_zero_reg(w_dump_address) ? '0 : r_regs[w_dump_address];
   assign o_busy          = w_busy;
   assign o_write_dropped = r_write_dropped;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: default configuration against a behavioural
// model with random stimulus, plus a zero-register/no-bypass/DEPTH=6 instance.
module tb_param_register_file;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default instance: DEPTH 8, 2 ports, BYPASS 1, ZERO_REG 0
   logic        write = 1'b0, complete = 1'b0, dump_ready = 1'b0;
   logic [2:0]  waddr = '0;
   logic [15:0] wdata = '0;
   logic [5:0]  raddr = '0;
   logic [31:0] rdata;
   logic        dv, dlast, ddone, busy, wdrop;
   logic [2:0]  daddr;
   logic [15:0] ddata;

   // second instance: DEPTH 6, 3 ports, BYPASS 0, ZERO_REG 1
   logic        z_write = 1'b0, z_complete = 1'b0, z_ready = 1'b0;
   logic [2:0]  z_waddr = '0;
   logic [15:0] z_wdata = '0;
   logic [8:0]  z_raddr = '0;
   logic [47:0] z_rdata;
   logic        z_dv, z_dlast, z_ddone, z_busy, z_wdrop;
   logic [2:0]  z_daddr;
   logic [15:0] z_ddata;

   param_register_file dut (
      .clk(clk), .rst_n(rst_n),
      .i_write(write), .i_write_address(waddr), .i_write_data(wdata),
      .i_read_address(raddr), .o_read_data(rdata),
      .i_complete(complete), .o_dump_valid(dv), .i_dump_ready(dump_ready),
      .o_dump_address(daddr), .o_dump_data(ddata), .o_dump_last(dlast),
      .o_dump_done(ddone), .o_busy(busy), .o_write_dropped(wdrop)
   );

   param_register_file #(
      .DATA_WIDTH(16), .DEPTH(6), .NUM_READ(3), .ZERO_REG(1), .BYPASS(0)
   ) dut_z (
      .clk(clk), .rst_n(rst_n),
      .i_write(z_write), .i_write_address(z_waddr), .i_write_data(z_wdata),
      .i_read_address(z_raddr), .o_read_data(z_rdata),
      .i_complete(z_complete), .o_dump_valid(z_dv), .i_dump_ready(z_ready),
      .o_dump_address(z_daddr), .o_dump_data(z_ddata), .o_dump_last(z_dlast),
      .o_dump_done(z_ddone), .o_busy(z_busy), .o_write_dropped(z_wdrop)
   );

   int n_vec = 0;
   int n_err = 0;

   // behavioural model of the default instance
   logic [15:0] m_regs [8];
   logic [15:0] m_snap [8];
   int          m_phase;      // 0 idle, 1 streaming words, 2 done pulse
   int          m_idx;
   bit          m_prev_c;
   bit          m_dropped;
   bit          p_stall;
   int          p_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_snap[i] = '0;
      end
      m_phase   = 0;
      m_idx     = 0;
      m_prev_c  = 1'b1;   // a level already high at reset release is not an edge
      m_dropped = 1'b0;
      p_stall   = 1'b0;
      p_addr    = 0;
   endtask

   function automatic logic [15:0] ref_read(input logic [2:0] a);
      if (write && m_phase == 0 && a == waddr)
         return wdata;
      return m_regs[a];
   endfunction

   task automatic check_main();
      for (int p = 0; p < 2; p++)
         chk($sformatf("rd%0d", p), 64'(rdata[p*16 +: 16]), 64'(ref_read(raddr[p*3 +: 3])));
      chk("dump_valid", 64'(dv), 64'(m_phase == 1));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("dump_done", 64'(ddone), 64'(m_phase == 2));
      chk("write_dropped", 64'(wdrop), 64'(m_dropped));
      chk("dump_last", 64'(dlast), 64'(m_phase == 1 && m_idx == 7));
      if (m_phase == 1) begin
         chk("dump_address", 64'(daddr), 64'(m_idx));
         chk("dump_data", 64'(ddata), 64'(m_snap[m_idx]));
         if (p_stall)
            chk("stall_hold", 64'(daddr), 64'(p_addr));
      end
   endtask

   task automatic model_update();
      p_stall = (m_phase == 1) && !dump_ready;
      p_addr  = m_idx;
      if (write && m_phase == 0)
         m_regs[waddr] = wdata;
      if (write && m_phase != 0)
         m_dropped = 1'b1;
      case (m_phase)
         0: if (complete && !m_prev_c) begin
               m_phase = 1;
               m_idx   = 0;
               m_snap  = m_regs;
            end
         1: if (dump_ready) begin
               if (m_idx == 7) m_phase = 2;
               else            m_idx++;
            end
         default: m_phase = 0;
      endcase
      m_prev_c = complete;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_main();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic zstep();
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      #2;
      check_main();
      chk("rst_dump_address", 64'(daddr), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) cycle();

      // r3 <= BEEF, read same cycle (bypass) and next cycle on port 1
      write = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr = {3'd3, 3'd0};
      #1 chk("bypass_same_cycle", 64'(rdata[31:16]), 64'h BEEF);
      cycle();
      write = 1'b0;
      #1 chk("read_next_cycle", 64'(rdata[31:16]), 64'h BEEF);
      cycle();

      // r_i = 0x1000+i, then full-speed dump
      for (int i = 0; i < 8; i++) begin
         write = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
         cycle();
      end
      write = 1'b0; dump_ready = 1'b1; complete = 1'b1;
      cycle();
      for (int k = 0; k < 8; k++) begin
         chk("seq_address", 64'(daddr), 64'(k));
         chk("seq_data", 64'(ddata), 64'h1000 + 64'(k));
         chk("seq_last", 64'(dlast), 64'(k == 7));
         cycle();
      end
      chk("seq_done", 64'(ddone), 64'd1);
      cycle();
      chk("seq_idle", 64'(busy), 64'd0);
      complete = 1'b0;
      cycle();

      // random traffic with dumps, random stalls and writes during dumps
      for (int d = 0; d < 6; d++) begin
         int hold;
         hold = int'($urandom_range(1, 20));
         for (int c = 0; c < 60; c++) begin
            write      = 1'($urandom_range(0, 1));
            waddr      = 3'($urandom_range(0, 7));
            wdata      = 16'($urandom);
            raddr      = 6'($urandom_range(0, 63));
            dump_ready = 1'($urandom_range(0, 1));
            complete   = (c >= 10) && (c < 10 + hold);
            cycle();
         end
      end

      // dump with a dropped r2 write during a stall, then reset at word 4
      write = 1'b0; complete = 1'b0; dump_ready = 1'b1; raddr = {3'd2, 3'd2};
      repeat (2) cycle();
      complete = 1'b1;
      cycle();
      dump_ready = 1'b0; write = 1'b1; waddr = 3'd2; wdata = 16'hDEAD;
      cycle();
      write = 1'b0;
      chk("drop_flag", 64'(wdrop), 64'd1);
      dump_ready = 1'b1;
      repeat (4) cycle();
      chk("at_word4", 64'(daddr), 64'd4);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 64'(dv), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(ddone), 64'd0);
      chk("abort_dropped", 64'(wdrop), 64'd0);
      chk("abort_last", 64'(dlast), 64'd0);
      chk("abort_address", 64'(daddr), 64'd0);
      chk("abort_read", 64'(rdata), 64'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) cycle();
      chk("no_retrigger", 64'(busy), 64'd0);
      complete = 1'b0;
      cycle();
      complete = 1'b1;
      cycle();
      chk("retrigger_valid", 64'(dv), 64'd1);
      repeat (12) cycle();
      complete = 1'b0;
      cycle();

      // zero-register / no-bypass / DEPTH 6 instance
      z_write = 1'b1; z_waddr = 3'd0; z_wdata = 16'h1234; z_raddr = '0;
      #1 chk("z_r0_same", 64'(z_rdata), 64'd0);
      zstep();
      z_write = 1'b0;
      #1 chk("z_r0_after", 64'(z_rdata), 64'd0);
      chk("z_r0_no_drop", 64'(z_wdrop), 64'd0);
      z_write = 1'b1; z_waddr = 3'd3; z_wdata = 16'hBEEF; z_raddr = {3'd3, 3'd3, 3'd3};
      #1 chk("z_nobypass", 64'(z_rdata), 64'd0);
      zstep();
      z_write = 1'b0;
      #1 chk("z_read_next", 64'(z_rdata), 64'h BEEF_BEEF_BEEF);
      z_write = 1'b1; z_waddr = 3'd7; z_wdata = 16'h5555; z_raddr = {3'd7, 3'd6, 3'd7};
      zstep();
      z_write = 1'b0;
      #1 chk("z_out_of_range", 64'(z_rdata), 64'd0);
      for (int i = 1; i < 6; i++) begin
         z_write = 1'b1; z_waddr = 3'(i); z_wdata = 16'h2000 + 16'(i);
         zstep();
      end
      z_write = 1'b0; z_ready = 1'b1; z_complete = 1'b1;
      zstep();
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("z_seq_valid", 64'(z_dv), 64'd1);
         chk("z_seq_address", 64'(z_daddr), 64'(k));
         chk("z_seq_data", 64'(z_ddata), (k == 0) ? 64'd0 : 64'h2000 + 64'(k));
         chk("z_seq_last", 64'(z_dlast), 64'(k == 5));
         zstep();
      end
      #1 chk("z_done", 64'(z_ddone), 64'd1);
      zstep();
      #1 chk("z_idle", 64'(z_busy), 64'd0);
      z_complete = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
